// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register bank.
// Holds the AXI response encodings and the state typedefs of the write and read
// channel FSMs so that the top level and any future AXI-Lite slaves agree on them.
package axil_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Write path: idle, one of AW/W captured, response pending
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_HALF = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Read path: waiting for an address, or holding read data
    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axil_wstrb_merge.sv
// Byte-masked merge of a stored word with new write data.
// Ports:
//   old_data - current register contents
//   new_data - incoming write data
//   strb     - byte enables; a set bit takes that byte from new_data
//   merged   - resulting word
module axil_wstrb_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_data,
    input  logic [DW-1:0]   new_data,
    input  logic [DW/8-1:0] strb,
    output logic [DW-1:0]   merged
);

    always_comb begin
        merged = old_data;
        for (int b = 0; b < DW / 8; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS word-sized registers.
// Registers selected by RO_MASK are read-only: reads return regs_in and writes
// answer SLVERR without effect. Out-of-range indices answer DECERR.
// Ports:
//   ACLK, ARESET        - clock and synchronous active-high reset
//   S_AXI_AW*/W*/B*     - write address, write data and write response channels
//   S_AXI_AR*/R*        - read address and read data channels
//   regs_out            - flattened register contents, reg i at [i*DW +: DW]
//   regs_in             - hardware values shown by read-only registers
//   wr_pulse            - one-cycle strobe per register on an accepted write
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_in,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int IDX_W    = AW - ADDR_LSB;

    wr_state_t           w_state;
    rd_state_t           r_state;
    logic                aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0]          b_resp, r_resp;
    logic [DW-1:0]       r_data;
    logic [NUM_REGS-1:0] pulse;
    logic [IDX_W-1:0]    aw_idx_hold;
    logic [DW-1:0]       w_data_hold;
    logic [SW-1:0]       w_strb_hold;
    logic [DW-1:0]       regs    [NUM_REGS];
    logic [DW-1:0]       cur_val [NUM_REGS];

    logic                aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [DW-1:0]       wr_data, wr_old, wr_merged, rd_val;
    logic [SW-1:0]       wr_strb;
    logic [NUM_REGS-1:0] wr_hit;
    logic                wr_in_range, wr_ro, wr_ok, rd_in_range;
    logic [1:0]          wr_resp;
    logic                unused;

    assign aw_hs = S_AXI_AWVALID && aw_ready;
    assign w_hs  = S_AXI_WVALID && w_ready;
    assign ar_hs = S_AXI_ARVALID && ar_ready;

    // The write resolves on the edge where the last of AW/W arrives, so the
    // effective address/data come from the bus when that item is handshaking
    // now, otherwise from the item captured earlier.
    assign wr_idx  = aw_hs ? S_AXI_AWADDR[AW-1:ADDR_LSB] : aw_idx_hold;
    assign wr_data = w_hs ? S_AXI_WDATA : w_data_hold;
    assign wr_strb = w_hs ? S_AXI_WSTRB : w_strb_hold;
    assign rd_idx  = S_AXI_ARADDR[AW-1:ADDR_LSB];
    assign commit  = ((w_state == W_IDLE) && aw_hs && w_hs) ||
                     ((w_state == W_HALF) && (aw_hs || w_hs));

    // Visible value of each register: hardware input for read-only slots
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cur_val[i] = RO_MASK[i] ? regs_in[i*DW +: DW] : regs[i];
            regs_out[i*DW +: DW] = cur_val[i];
        end
    end

    // Index decode for both paths; an index matching no register is out of range
    always_comb begin
        wr_hit      = '0;
        wr_in_range = 1'b0;
        wr_ro       = 1'b0;
        wr_old      = '0;
        rd_in_range = 1'b0;
        rd_val      = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                wr_hit[i]   = 1'b1;
                wr_in_range = 1'b1;
                wr_ro       = RO_MASK[i];
                wr_old      = regs[i];
            end
            if (rd_idx == IDX_W'(i)) begin
                rd_in_range = 1'b1;
                rd_val      = cur_val[i];
            end
        end
    end

    assign wr_ok   = wr_in_range && !wr_ro;
    assign wr_resp = !wr_in_range ? RESP_DECERR : (wr_ro ? RESP_SLVERR : RESP_OKAY);

    axil_wstrb_merge #(.DW(DW)) u_merge (
        .old_data (wr_old),
        .new_data (wr_data),
        .strb     (wr_strb),
        .merged   (wr_merged)
    );

    // Register storage; read-only slots are never written
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i] && !RO_MASK[i]) begin
                    regs[i] <= wr_merged;
                end
            end
        end
    end

    // Write FSM. Ready flags are registers so they stay low through reset and
    // the first cycle after it, and drop as soon as their item is captured.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state     <= W_IDLE;
            aw_ready    <= 1'b0;
            w_ready     <= 1'b0;
            b_valid     <= 1'b0;
            b_resp      <= RESP_OKAY;
            pulse       <= '0;
            aw_idx_hold <= '0;
            w_data_hold <= '0;
            w_strb_hold <= '0;
        end else begin
            pulse <= '0;
            if (aw_hs) begin
                aw_idx_hold <= S_AXI_AWADDR[AW-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_data_hold <= S_AXI_WDATA;
                w_strb_hold <= S_AXI_WSTRB;
            end
            if (commit) begin
                w_state  <= W_RESP;
                aw_ready <= 1'b0;
                w_ready  <= 1'b0;
                b_valid  <= 1'b1;
                b_resp   <= wr_resp;
                if (wr_ok) begin
                    pulse <= wr_hit;
                end
            end else begin
                case (w_state)
                    W_IDLE: begin
                        if (aw_hs) begin
                            w_state  <= W_HALF;
                            aw_ready <= 1'b0;
                            w_ready  <= 1'b1;
                        end else if (w_hs) begin
                            w_state  <= W_HALF;
                            aw_ready <= 1'b1;
                            w_ready  <= 1'b0;
                        end else begin
                            aw_ready <= 1'b1;
                            w_ready  <= 1'b1;
                        end
                    end
                    W_HALF: begin
                        w_state <= W_HALF;
                    end
                    W_RESP: begin
                        if (b_valid && S_AXI_BREADY) begin
                            w_state  <= W_IDLE;
                            b_valid  <= 1'b0;
                            aw_ready <= 1'b1;
                            w_ready  <= 1'b1;
                        end
                    end
                    default: begin
                        w_state <= W_IDLE;
                    end
                endcase
            end
        end
    end

    // Read FSM. Data is sampled from the pre-edge register values, so a read
    // captured on the same edge as a write commit sees the old contents.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state  <= R_RESP;
                        ar_ready <= 1'b0;
                        r_valid  <= 1'b1;
                        r_data   <= rd_val;
                        r_resp   <= rd_in_range ? RESP_OKAY : RESP_DECERR;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (r_valid && S_AXI_RREADY) begin
                        r_state  <= R_IDLE;
                        r_valid  <= 1'b0;
                        ar_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = r_resp;
    assign wr_pulse      = pulse;

    // Protection bits, sub-word address bits and the writable-slot part of
    // regs_in carry no meaning here
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                      S_AXI_ARADDR[ADDR_LSB-1:0], regs_in};

endmodule

// File: tb/tb_axil_reg_bank.sv
// Scoreboard bench for axil_reg_bank: 32-bit data, 16 registers, reg 1 read-only.
// Stimulus pushes the expected B/R responses into queues; a negedge monitor
// compares every presented response (and wr_pulse every cycle) against them.
module tb_axil_reg_bank;
    import axil_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0002;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [AW-1:0]    S_AXI_AWADDR;
    logic [2:0]       S_AXI_AWPROT;
    logic             S_AXI_AWVALID;
    logic             S_AXI_AWREADY;
    logic [DW-1:0]    S_AXI_WDATA;
    logic [DW/8-1:0]  S_AXI_WSTRB;
    logic             S_AXI_WVALID;
    logic             S_AXI_WREADY;
    logic [1:0]       S_AXI_BRESP;
    logic             S_AXI_BVALID;
    logic             S_AXI_BREADY;
    logic [AW-1:0]    S_AXI_ARADDR;
    logic [2:0]       S_AXI_ARPROT;
    logic             S_AXI_ARVALID;
    logic             S_AXI_ARREADY;
    logic [DW-1:0]    S_AXI_RDATA;
    logic [1:0]       S_AXI_RRESP;
    logic             S_AXI_RVALID;
    logic             S_AXI_RREADY;
    logic [NR*DW-1:0] regs_out;
    logic [NR*DW-1:0] regs_in;
    logic [NR-1:0]    wr_pulse;

    typedef struct {
        logic [1:0]    resp;
        logic [NR-1:0] pulse;
    } b_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } r_exp_t;

    b_exp_t        b_queue[$];
    r_exp_t        r_queue[$];
    int            tests = 0;
    int            failures = 0;
    logic          b_valid_prev = 1'b0;
    logic [NR-1:0] exp_pulse;

    axil_reg_bank #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR),
        .RO_MASK            (RO)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .regs_out      (regs_out),
        .regs_in       (regs_in),
        .wr_pulse      (wr_pulse)
    );

    // 100 MHz clock
    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failEvent(input string name);
        tests++;
        failures++;
        $display("[TB] FAIL %s: got no event, expected one within the cycle bound", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic sendAw(input logic [AW-1:0] addr);
        int n;
        n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!S_AXI_AWREADY && n < 50);
        if (!S_AXI_AWREADY) failEvent("awready_wait");
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic sendW(input logic [DW-1:0] data, input logic [3:0] strb);
        int n;
        n = 0;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_WVALID = 1'b1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!S_AXI_WREADY && n < 50);
        if (!S_AXI_WREADY) failEvent("wready_wait");
        @(posedge ACLK);
        #1;
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic sendAr(input logic [AW-1:0] addr);
        int n;
        n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!S_AXI_ARREADY && n < 50);
        if (!S_AXI_ARREADY) failEvent("arready_wait");
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    // Issue one write; w_lead > 0 presents W that many cycles before AW,
    // w_lead < 0 presents AW first, 0 presents both together
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [3:0] strb, input logic [1:0] resp,
                                 input logic [NR-1:0] pulse, input int w_lead);
        b_queue.push_back(b_exp_t'{resp: resp, pulse: pulse});
        if (w_lead == 0) begin
            fork
                sendAw(addr);
                sendW(data, strb);
            join
        end else if (w_lead > 0) begin
            fork
                sendW(data, strb);
                begin
                    repeat (w_lead) tick();
                    sendAw(addr);
                end
            join
        end else begin
            fork
                sendAw(addr);
                begin
                    repeat (-w_lead) tick();
                    sendW(data, strb);
                end
            join
        end
    endtask

    task automatic applyRead(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] resp);
        r_queue.push_back(r_exp_t'{data: data, resp: resp});
        sendAr(addr);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((b_queue.size() != 0 || r_queue.size() != 0 || S_AXI_BVALID || S_AXI_RVALID) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) failEvent("idle_wait");
    endtask

    task automatic doReset(input int cycles);
        ARESET = 1'b1;
        b_queue.delete();
        r_queue.delete();
        repeat (cycles) tick();
        ARESET = 1'b0;
    endtask

    // Monitor: compares each presented response with the queue head; a stalled
    // response is compared every cycle, so any drift while stalled is caught
    always @(negedge ACLK) begin
        if (!ARESET) begin
            exp_pulse = '0;
            if (S_AXI_BVALID && !b_valid_prev && b_queue.size() > 0) exp_pulse = b_queue[0].pulse;
            checkOutput("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
            if (S_AXI_BVALID) begin
                if (b_queue.size() == 0) begin
                    failEvent("bvalid_without_write");
                end else begin
                    checkOutput("bresp", 64'(S_AXI_BRESP), 64'(b_queue[0].resp));
                    if (S_AXI_BREADY) void'(b_queue.pop_front());
                end
            end
            if (S_AXI_RVALID) begin
                if (r_queue.size() == 0) begin
                    failEvent("rvalid_without_read");
                end else begin
                    checkOutput("rdata", 64'(S_AXI_RDATA), 64'(r_queue[0].data));
                    checkOutput("rresp", 64'(S_AXI_RRESP), 64'(r_queue[0].resp));
                    if (S_AXI_RREADY) void'(r_queue.pop_front());
                end
            end
        end
        b_valid_prev = S_AXI_BVALID;
    end

    // Watchdog
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [AW-1:0] vec_addr  [4] = '{8'h00, 8'h04, 8'h08, 8'h0C};
    logic [DW-1:0] vec_wdata [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
    logic [1:0]    vec_bresp [4] = '{RESP_OKAY, RESP_SLVERR, RESP_OKAY, RESP_OKAY};
    logic [NR-1:0] vec_pulse [4] = '{16'h0001, 16'h0000, 16'h0004, 16'h0008};
    logic [DW-1:0] vec_rdata [4] = '{32'h1, 32'hCAFE0001, 32'h3, 32'h4};

    initial begin
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = 3'b000;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = 3'b000;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        for (int i = 0; i < NR; i++) regs_in[i*DW +: DW] = 32'hA5A50000 | i;
        regs_in[1*DW +: DW] = 32'hCAFE0001;

        // Reset state, during reset and in the first cycle after it
        repeat (3) tick();
        checkOutput("rst_awready", 64'(S_AXI_AWREADY), 0);
        checkOutput("rst_bvalid", 64'(S_AXI_BVALID), 0);
        checkOutput("rst_rvalid", 64'(S_AXI_RVALID), 0);
        ARESET = 1'b0;
        checkOutput("post_rst_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 0);
        checkOutput("post_rst_rdata", 64'(S_AXI_RDATA), 0);
        checkOutput("post_rst_resps", 64'({S_AXI_BRESP, S_AXI_RRESP}), 0);
        checkOutput("post_rst_pulse", 64'(wr_pulse), 0);
        checkOutput("reg0_after_reset", 64'(regs_out[0 +: DW]), 0);
        checkOutput("ro_regs_out", 64'(regs_out[1*DW +: DW]), 64'h0000_0000_CAFE_0001);
        tick();
        checkOutput("readies_up", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'h7);

        // Four writes with varied AW/W ordering, then read back
        for (int i = 0; i < 4; i++) applyStimulus(vec_addr[i], vec_wdata[i], 4'hF, vec_bresp[i], vec_pulse[i], i - 1);
        for (int i = 0; i < 4; i++) applyRead(vec_addr[i], vec_rdata[i], RESP_OKAY);

        // W presented three cycles ahead of AW
        waitIdle();
        b_queue.push_back(b_exp_t'{resp: RESP_OKAY, pulse: 16'h0004});
        sendW(32'hDEADBEEF, 4'hF);
        repeat (2) tick();
        checkOutput("no_b_before_aw", 64'(S_AXI_BVALID), 0);
        checkOutput("half_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'h2);
        sendAw(8'h08);
        checkOutput("bvalid_after_aw", 64'(S_AXI_BVALID), 1);
        applyRead(8'h08, 32'hDEADBEEF, RESP_OKAY);

        // Byte strobes
        applyStimulus(8'h14, 32'hFFFFFFFF, 4'hF, RESP_OKAY, 16'h0020, 0);
        applyStimulus(8'h14, 32'h12345678, 4'b0101, RESP_OKAY, 16'h0020, 1);
        applyRead(8'h14, 32'hFF34FF78, RESP_OKAY);
        applyStimulus(8'h14, 32'h00000000, 4'b0000, RESP_OKAY, 16'h0020, 0);
        applyRead(8'h14, 32'hFF34FF78, RESP_OKAY);
        applyStimulus(8'h14, 32'hAABBCCDD, 4'b1010, RESP_OKAY, 16'h0020, -1);
        applyRead(8'h14, 32'hAA34CC78, RESP_OKAY);

        // Range edges and ignored low address bits
        applyStimulus(8'h40, 32'h11111111, 4'hF, RESP_DECERR, 16'h0000, 0);
        applyRead(8'h40, 32'h0, RESP_DECERR);
        applyStimulus(8'h3F, 32'h0000F00D, 4'hF, RESP_OKAY, 16'h8000, 0);
        applyRead(8'h3C, 32'h0000F00D, RESP_OKAY);
        applyRead(8'h0B, 32'hDEADBEEF, RESP_OKAY);
        waitIdle();
        checkOutput("regs_out_reg2", 64'(regs_out[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);

        // Read captured on the same edge as a write commit sees the old value
        b_queue.push_back(b_exp_t'{resp: RESP_OKAY, pulse: 16'h0008});
        r_queue.push_back(r_exp_t'{data: 32'h4, resp: RESP_OKAY});
        fork
            sendAw(8'h0C);
            sendW(32'h00000055, 4'hF);
            sendAr(8'h0C);
        join
        applyRead(8'h0C, 32'h55, RESP_OKAY);

        // Ten-cycle stall on both response channels
        waitIdle();
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        b_queue.push_back(b_exp_t'{resp: RESP_OKAY, pulse: 16'h0040});
        r_queue.push_back(r_exp_t'{data: 32'hDEADBEEF, resp: RESP_OKAY});
        fork
            sendAw(8'h18);
            sendW(32'h00000066, 4'hF);
            sendAr(8'h08);
        join
        repeat (10) tick();
        checkOutput("stall_ready", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 0);
        checkOutput("stall_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'h3);
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        applyRead(8'h18, 32'h66, RESP_OKAY);

        // Reset while both responses are stalled
        waitIdle();
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        b_queue.push_back(b_exp_t'{resp: RESP_OKAY, pulse: 16'h0001});
        r_queue.push_back(r_exp_t'{data: 32'h1, resp: RESP_OKAY});
        fork
            sendAw(8'h00);
            sendW(32'h00000077, 4'hF);
            sendAr(8'h00);
        join
        repeat (3) tick();
        doReset(2);
        checkOutput("mid_rst_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 0);
        checkOutput("mid_rst_rdata", 64'(S_AXI_RDATA), 0);
        checkOutput("mid_rst_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 0);
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        repeat (3) tick();
        checkOutput("no_stale_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 0);
        applyRead(8'h00, 32'h0, RESP_OKAY);
        applyRead(8'h18, 32'h0, RESP_OKAY);
        applyRead(8'h08, 32'h0, RESP_OKAY);
        applyRead(8'h04, 32'hCAFE0001, RESP_OKAY);

        // Reset with only AW captured leaves no half transaction behind
        waitIdle();
        sendAw(8'h00);
        doReset(1);
        tick();
        checkOutput("idle_after_abandon", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'h3);
        applyStimulus(8'h00, 32'h00000099, 4'hF, RESP_OKAY, 16'h0001, 0);
        applyRead(8'h00, 32'h99, RESP_OKAY);

        waitIdle();
        checkOutput("queues_drained", 64'(b_queue.size() + r_queue.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning the data bus width; legal values are 32 and 64.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, meaning the byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, meaning the register count; legal range is 1 to 2^(C_S_AXI_ADDR_WIDTH-ADDR_LSB).
REQ-004 SHALL have parameter RO_MASK, default 0, meaning per-register read-only select (NUM_REGS bits; bit i=1 makes reg i read-only).
REQ-005 SHALL have one clock; reset is synchronous and active-high; ports ACLK and ARESET.
REQ-006 SHALL have ports as follows (name, direction, width, meaning):
- ACLK, in, 1, clock.
- ARESET, in, 1, synchronous active-high reset.
- S_AXI_AWADDR, in, ADDR, write address.
- S_AXI_AWPROT, in, 3, ignored.
- S_AXI_AWVALID / S_AXI_AWREADY, in / out, 1, write-address handshake.
- S_AXI_WDATA, in, DW, write data.
- S_AXI_WSTRB, in, DW/8, byte enables.
- S_AXI_WVALID / S_AXI_WREADY, in / out, 1, write-data handshake.
- S_AXI_BRESP, out, 2, write response.
- S_AXI_BVALID / S_AXI_BREADY, out / in, 1, write-response handshake.
- S_AXI_ARADDR, in, ADDR, read address.
- S_AXI_ARPROT, in, 3, ignored.
- S_AXI_ARVALID / S_AXI_ARREADY, in / out, 1, read-address handshake.
- S_AXI_RDATA, out, DW, read data.
- S_AXI_RRESP, out, 2, read response.
- S_AXI_RVALID / S_AXI_RREADY, out / in, 1, read-data handshake.
- regs_out, out, NUM_REGS*DW, flattened register contents (reg i at [i*DW +: DW]).
- regs_in, in, NUM_REGS*DW, hardware values for read-only registers.
- wr_pulse, out, NUM_REGS, one-cycle strobe per register on a committed write.

Function
REQ-007 SHALL define ADDR_LSB = clog2(DW/8) and register index = AWADDR/ARADDR >> ADDR_LSB; low address bits are ignored.
REQ-008 SHALL accept AW and W independently, in either order or in the same cycle; each READY is high while its item is not yet captured and no response is pending.
REQ-009 SHALL use a write FSM with states W_IDLE, W_HALF (one of AW/W captured) and W_RESP.
- W_IDLE -> W_RESP when both handshakes occur in one cycle.
- W_IDLE -> W_HALF when only one occurs.
- W_HALF -> W_RESP when the other arrives.
- W_RESP -> W_IDLE on BVALID&&BREADY.
REQ-010 SHALL commit a write on the clock edge entering W_RESP, updating only bytes with WSTRB=1; BVALID is high from the next cycle.
REQ-011 SHALL return BRESP=OKAY(00) for an in-range writable index, SLVERR(10) for a read-only index (no update, no wr_pulse), and DECERR(11) for index >= NUM_REGS (no update).
REQ-012 SHALL pulse wr_pulse[i] for exactly one cycle, aligned with the first BVALID cycle, on a committed OKAY write to reg i, including when WSTRB=0.
REQ-013 SHALL use a read FSM with states R_IDLE (ARREADY=1) and R_RESP (ARREADY=0, RVALID=1).
- The AR handshake in cycle N captures RDATA/RRESP at that edge; RVALID is high in cycle N+1.
- RDATA and RRESP hold stable until RVALID&&RREADY; the FSM returns to R_IDLE on the next edge.
REQ-014 SHALL return regs_in[i] for a read-only reg and the stored value otherwise, with RRESP=OKAY; for index >= NUM_REGS it SHALL return RDATA=0 and RRESP=DECERR.
REQ-015 SHALL return the pre-write value when a read is captured on the same edge as a write commit to the same register.
REQ-016 SHALL keep the read and write paths fully independent, with at most one outstanding transaction per path.
REQ-017 SHALL drive regs_out[i] = regs_in[i] for read-only registers.

Reset
REQ-018 SHALL, while ARESET=1 at an edge, clear all writable registers to 0 and return both FSMs to IDLE.
REQ-019 SHALL hold every READY, BVALID and RVALID low, BRESP/RRESP=00, RDATA=0 and wr_pulse=0 during reset and in the first cycle after it.
REQ-020 SHALL abandon any in-flight transaction when reset is asserted mid-operation, with no partial commit and no late response.

Structure
REQ-021 SHALL take the AXI response encodings (OKAY, SLVERR, DECERR) and the FSM state typedefs from shared package axil_pkg.
REQ-022 SHALL contain one sub-module, axil_wstrb_merge (byte-masked merge of old and new data).

Verification
REQ-023 Reset, then with DW=32 write 0x1,0x2,0x3,0x4 to addresses 0x0-0xC and read them back -> each read returns the written value with OKAY.
REQ-024 Present W 3 cycles before AW (data 0xDEADBEEF, addr 0x8) -> BVALID follows AW by one cycle, BRESP=OKAY and wr_pulse[2] pulses once.
REQ-025 Preload 0xFFFFFFFF, then write 0x12345678 with WSTRB=0101 -> read returns 0xFF34FF78.
REQ-026 RO_MASK=0x2 with regs_in reg1=0xCAFE0001: write to 0x4 -> SLVERR and the value is unchanged; read 0x4 -> 0xCAFE0001 with OKAY.
REQ-027 NUM_REGS=16: access 0x40 -> write BRESP=DECERR; read RDATA=0 with RRESP=DECERR.
REQ-028 Hold BREADY/RREADY low for 10 cycles, and assert ARESET mid-transaction -> BRESP/RRESP and RDATA stay stable while stalled; after reset there is no stale BVALID/RVALID and registers read as 0.
